// File: rtl/imc_shift_accumulator_pkg.sv
// Shared types and defaults for the IMC shift-accumulator slice.
// Optional macro IMC_ACC_RELU_EN is consumed by the top module.
package imc_acc_pkg;

  localparam int NUM_COLS_D = 16;
  localparam int ADC_W_D    = 4;
  localparam int MAX_BITS_D = 8;
  localparam int ACC_W_D    = ADC_W_D + MAX_BITS_D + 1;
  localparam int OUT_W_D    = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  // LSB position of column c on the packed ADC bus
  function automatic int col_off(
    input int c,
    input int w
  );
    return c * w;
  endfunction

endpackage

// File: rtl/imc_shift_accumulator_if.sv
// ADC input strobe and output-buffer write port of the accumulator.
// master = array/buffer side, slave = accumulator side.
interface imc_shift_accumulator_if
  import imc_acc_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_D,
  parameter int ADC_W    = ADC_W_D,
  parameter int OUT_W    = OUT_W_D
);

  logic [NUM_COLS*ADC_W-1:0] imc_data;
  logic                      imc_valid;
  logic                      out_wr_en;
  logic [OUT_W-1:0]          out_data;
  logic                      out_full;

  modport master (
    output imc_data,
    output imc_valid,
    output out_full,
    input  out_wr_en,
    input  out_data
  );

  modport slave (
    input  imc_data,
    input  imc_valid,
    input  out_full,
    output out_wr_en,
    output out_data
  );

endinterface

// File: rtl/imc_shift_accumulator_col_acc.sv
// One column accumulator: shifted ADC sample added or subtracted
// into an ACC_W two's complement register.
module imc_col_acc
  import imc_acc_pkg::*;
#(
  parameter int ADC_W    = ADC_W_D,
  parameter int MAX_BITS = MAX_BITS_D,
  parameter int ACC_W    = ACC_W_D,
  parameter int SH_W     = $clog2(MAX_BITS)
) (
  input  logic             clk,
  input  logic             cntrl_reset,
  input  logic             clr,
  input  logic             en,
  input  logic             sub,
  input  logic [SH_W-1:0]  shamt,
  input  logic [ADC_W-1:0] adc,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] term;

  assign term = ACC_W'(adc) << shamt;

  // clear on start, shift-add (or MSB-plane subtract) on valid
  always_ff @(posedge clk or posedge cntrl_reset) begin
    if (cntrl_reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sub ? acc - term : acc + term;
    end
  end

endmodule

// File: rtl/imc_shift_accumulator.sv
// Bit-serial shift-accumulate of IMC ADC planes, paired-word drain.
// Define IMC_ACC_RELU_EN to clamp negative sums to 0 on output.
module imc_shift_accumulator
  import imc_acc_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_D,
  parameter int ADC_W    = ADC_W_D,
  parameter int MAX_BITS = MAX_BITS_D,
  parameter int ACC_W    = ACC_W_D,
  parameter int OUT_W    = OUT_W_D
) (
  input  logic       clk,
  input  logic       cntrl_reset,
  input  logic       start,
  input  logic [3:0] num_bits,
  input  logic       signed_mode,
  output logic       busy,
  output logic       done,
  imc_shift_accumulator_if.slave bus
);

  localparam int SH_W  = $clog2(MAX_BITS);
  localparam int WORDS = NUM_COLS / 2;
  localparam int WI_W  = $clog2(WORDS);
  localparam int HALF  = OUT_W / 2;

  localparam logic [3:0]      MAXB4 = 4'(MAX_BITS);
  localparam logic [SH_W-1:0] MAXL  = SH_W'(MAX_BITS - 1);
  localparam logic [WI_W-1:0] WLAST = WI_W'(WORDS - 1);

  state_t          state;
  state_t          state_nx;
  logic [SH_W-1:0] bit_idx;
  logic [SH_W-1:0] last_idx;
  logic [SH_W-1:0] last_sel;
  logic            sgn;
  logic [WI_W-1:0] word_idx;
  logic            last_plane;
  logic            acc_en;
  logic            clr;
  logic            wr_en;

  logic [ACC_W-1:0] acc [NUM_COLS];
  logic [ACC_W-1:0] acc_lo;
  logic [ACC_W-1:0] acc_hi;

  assign last_plane = (bit_idx == last_idx);
  assign clr        = (state == IDLE) && start;
  assign acc_en     = (state == ACCUM) && bus.imc_valid;

  // out-of-range plane counts fall back to the full depth
  always_comb begin
    last_sel = MAXL;
    if (num_bits != 4'd0 && num_bits <= MAXB4)
      last_sel = SH_W'(num_bits - 4'd1);
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    imc_col_acc #(
      .ADC_W   (ADC_W),
      .MAX_BITS(MAX_BITS),
      .ACC_W   (ACC_W),
      .SH_W    (SH_W)
    ) u_col (
      .clk        (clk),
      .cntrl_reset(cntrl_reset),
      .clr        (clr),
      .en         (acc_en),
      .sub        (sgn && last_plane),
      .shamt      (bit_idx),
      .adc        (bus.imc_data[col_off(c, ADC_W) +: ADC_W]),
      .acc        (acc[c])
    );
  end

  // state register
  always_ff @(posedge clk or posedge cntrl_reset) begin
    if (cntrl_reset) state <= IDLE;
    else             state <= state_nx;
  end

  // next state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    wr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (acc_en && last_plane) state_nx = DRAIN;
      end
      DRAIN: begin
        busy  = 1'b1;
        wr_en = !bus.out_full;
        if (wr_en && word_idx == WLAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operation config latch and plane / word counters
  always_ff @(posedge clk or posedge cntrl_reset) begin
    if (cntrl_reset) begin
      bit_idx  <= '0;
      last_idx <= '0;
      sgn      <= 1'b0;
      word_idx <= '0;
    end else begin
      if (clr) begin
        bit_idx  <= '0;
        last_idx <= last_sel;
        sgn      <= signed_mode;
        word_idx <= '0;
      end
      if (acc_en) begin
        if (last_plane) word_idx <= '0;
        else            bit_idx  <= bit_idx + 1'b1;
      end
      if (wr_en) word_idx <= word_idx + 1'b1;
    end
  end

  function automatic logic [HALF-1:0] present(
    input logic [ACC_W-1:0] a
  );
`ifdef IMC_ACC_RELU_EN
    if (a[ACC_W-1]) return '0;
`endif
    return {{(HALF-ACC_W){a[ACC_W-1]}}, a};
  endfunction

  assign acc_lo = acc[{word_idx, 1'b0}];
  assign acc_hi = acc[{word_idx, 1'b1}];

  assign bus.out_wr_en = wr_en;
  assign bus.out_data  = {present(acc_hi), present(acc_lo)};

endmodule

// File: doc/imc_shift_accumulator.md
Name: imc_shift_accumulator

Overview:
- Downstream stage of the SRAM in-memory-compute (IMC) array.
- Consumes the 64-bit packed ADC result bus, 16 columns × 4 bits.
- Inputs are applied bit-serially, LSB first, over num_bits array cycles. For each column the block shift-adds one ADC sample per input-bit plane into a per-column accumulator.
- When all planes are in, the block drains the 16 sums as 32-bit words into the output buffer write port, under backpressure.

Parameters:
- NUM_COLS, 16: number of array columns / ADCs. Must be even.
- ADC_W, 4: bits per ADC output.
- MAX_BITS, 8: maximum input bit-planes per operation.
- ACC_W, 13: accumulator width. Equals ADC_W + MAX_BITS + 1 (sign bit).
- OUT_W, 32: output buffer word width. Carries two 16-bit sign-extended sums.

Ports:
- clk  input  1: common clock.
- cntrl_reset  input  1: asynchronous, active-high reset.
- start  input  1: one-cycle pulse that begins an operation. Sampled only in IDLE.
- num_bits  input  4: number of input bit-planes, 1..MAX_BITS. Latched on start.
- signed_mode  input  1: 1 = MSB plane carries negative weight (two's complement input). Latched on start.
- imc_data  input  NUM_COLS*ADC_W: ADC outputs. Column c is at bits [c*ADC_W +: ADC_W].
- imc_valid  input  1: one-cycle strobe marking imc_data valid. Driven by the controller's data-ready output.
- busy  output  1: high in ACCUM and DRAIN.
- done  output  1: one-cycle pulse after the last output word is written.
- out_wr_en  output  1: output buffer write enable.
- out_data  output  OUT_W: output buffer write data.
- out_full  input  1: output buffer full flag (backpressure).

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulators 0, bit_idx 0, word_idx 0.
- Reset is asynchronous. Asserting it mid-ACCUM or mid-DRAIN aborts immediately. No done pulse is produced and no partial write is completed.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - On start: latch num_bits and signed_mode, clear all accumulators and bit_idx, go to ACCUM.
  - num_bits of 0 or > MAX_BITS is latched as MAX_BITS.
  - imc_valid is ignored.
- ACCUM:
  - On each imc_valid, for every column: term = zero-extended adc[c] << bit_idx.
  - If signed_mode and bit_idx == nb-1, acc[c] <= acc[c] - term. Otherwise acc[c] <= acc[c] + term.
  - All arithmetic is ACC_W-bit two's complement. Overflow is impossible within the ranges: unsigned max 3825, signed range -1920..1905.
  - On the imc_valid with bit_idx == nb-1: go to DRAIN next cycle, word_idx = 0. Otherwise bit_idx increments.
  - Cycles without imc_valid hold state.
- DRAIN:
  - out_wr_en = (state==DRAIN) && !out_full. It is combinational from the registered state and out_full.
  - out_data = {sext16(acc[2k+1]), sext16(acc[2k])} with k = word_idx, also combinational.
  - word_idx increments only on cycles where out_wr_en is 1.
  - After word NUM_COLS/2-1 is written, go to DONE.
  - Holding out_full stalls the drain indefinitely. No word is dropped or duplicated.
  - imc_valid is ignored.
- DONE: done = 1 for exactly one cycle, then IDLE. Accumulators keep their values until the next start.
- start while busy or in DONE is ignored.
- Minimum latency: the first output write occurs the cycle after the final imc_valid. With out_full low throughout, done rises NUM_COLS/2 + 1 cycles after the final imc_valid.

Optional Feature:
- Macro IMC_ACC_RELU_EN.
- When defined: in DRAIN, any acc[c] that is negative (MSB = 1) is presented as 0 in out_data. Stored accumulators are unchanged.
- When undefined: raw sign-extended sums are output. No extra logic.

Decomposition:
- Package imc_acc_pkg holds:
  - localparams for the default NUM_COLS, ADC_W, MAX_BITS and ACC_W;
  - the state enum (IDLE/ACCUM/DRAIN/DONE);
  - a function computing the column slice offset.
- One sub-module, imc_col_acc: a single column accumulator (clear, enable, shift, subtract, ACC_W register). It is instantiated NUM_COLS times with generate.
- The FSM and drain mux stay in the top module.

Test Plan:
- Unsigned basic:
  - Stimulus: num_bits=2, signed_mode=0, all columns adc=3 on both imc_valid strobes, out_full=0.
  - Required: acc=3+6=9. Eight writes of 0x00090009, then a done pulse one cycle after the 8th write.
- Signed MSB subtract:
  - Stimulus: num_bits=2, signed_mode=1, column 0 adc=1 then 2, column 1 adc=0 then 1, others 0.
  - Required: word0 = 0xFFFEFFFD (col0 = 1-4 = -3, col1 = -2). Remaining words 0.
- Backpressure:
  - Stimulus: out_full high for 5 cycles starting at word_idx=3.
  - Required: out_wr_en low during the stall, out_data stable at word 3. Exactly 8 writes total, in order.
- Start during busy and stray valid:
  - Stimulus: start pulse in ACCUM and in DRAIN; imc_valid pulses in IDLE and in DRAIN.
  - Required: no state change, no accumulator change, results identical to the undisturbed run.
- Reset mid-operation:
  - Stimulus: assert cntrl_reset after 1 of 4 planes.
  - Required: busy=0, out_wr_en=0, done=0 asynchronously. A subsequent full run with num_bits=4, all adc=15 gives 225 (0x00E100E1).
- RELU (IMC_ACC_RELU_EN defined):
  - Stimulus: the signed case above.
  - Required: word0 = 0x00000000. With the macro undefined, word0 = 0xFFFEFFFD.
